// File: rtl/prince_iter_core.sv
// Iterative PRINCE encrypt/decrypt core: one forward, middle or inverse round per clock,
// with key whitening, round constants and alpha-reflection for decryption.
module prince_iter_core #(
  parameter logic [63:0] ALPHA = 64'hc0ac29b7c97c50dd
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         decrypt,
  input  logic [63:0]  din,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic [63:0]  dout
);

  typedef enum logic [2:0] {IDLE, FWD, MID, INV, FIN} fsm_t;

  fsm_t        r_fsm, w_fsm_nxt;
  logic [63:0] r_state, r_kw_out, r_kc, r_dout;
  logic [3:0]  r_ctr;
  logic        r_busy, r_done;

  logic [63:0] w_k0, w_k1, w_k0p, w_kw_in, w_kw_out_in, w_kc_in;
  logic [63:0] w_rc, w_rk, w_sx, w_msx, w_fwd, w_mid, w_iround;
  logic [63:0] w_state_d;
  logic [3:0]  w_ctr_d;
  logic        w_load, w_fin;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hb;  4'h1: sbox = 4'hf;  4'h2: sbox = 4'h3;  4'h3: sbox = 4'h2;
      4'h4: sbox = 4'ha;  4'h5: sbox = 4'hc;  4'h6: sbox = 4'h9;  4'h7: sbox = 4'h1;
      4'h8: sbox = 4'h6;  4'h9: sbox = 4'h7;  4'ha: sbox = 4'h8;  4'hb: sbox = 4'h0;
      4'hc: sbox = 4'he;  4'hd: sbox = 4'h5;  4'he: sbox = 4'hd;  default: sbox = 4'h4;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'hb;  4'h1: sbox_inv = 4'h7;  4'h2: sbox_inv = 4'h3;  4'h3: sbox_inv = 4'h2;
      4'h4: sbox_inv = 4'hf;  4'h5: sbox_inv = 4'hd;  4'h6: sbox_inv = 4'h8;  4'h7: sbox_inv = 4'h9;
      4'h8: sbox_inv = 4'ha;  4'h9: sbox_inv = 4'h6;  4'ha: sbox_inv = 4'h4;  4'hb: sbox_inv = 4'h0;
      4'hc: sbox_inv = 4'h5;  4'hd: sbox_inv = 4'he;  4'he: sbox_inv = 4'hc;  default: sbox_inv = 4'h1;
    endcase
  endfunction

  function automatic logic [63:0] s_layer(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 16; i++)
      y[4*i +: 4] = inv ? sbox_inv(x[4*i +: 4]) : sbox(x[4*i +: 4]);
    return y;
  endfunction

  // 16-bit M-hat block, MSB-first rows/columns: block (r,c) is M_k, k=(r+c+sel)%4,
  // and M_k is the 4x4 identity with its k-th diagonal bit cleared.
  function automatic logic [15:0] m_hat(input logic [15:0] x, input logic sel);
    logic [15:0] y;
    y = '0;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned b = 0; b < 4; b++)
        for (int unsigned c = 0; c < 4; c++)
          if (((r + c + {31'b0, sel}) % 4) != b)
            y[15 - (4*r + b)] = y[15 - (4*r + b)] ^ x[15 - (4*c + b)];
    return y;
  endfunction

  function automatic logic [63:0] m_prime(input logic [63:0] x);
    return {m_hat(x[63:48], 1'b0), m_hat(x[47:32], 1'b1),
            m_hat(x[31:16], 1'b1), m_hat(x[15:0],  1'b0)};
  endfunction

  // Nibble 0 is the most significant; output nibble i takes input nibble 5*i mod 16.
  function automatic logic [63:0] shift_rows(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    int unsigned j;
    y = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      j = (5 * i) % 16;
      if (inv) y[63 - 4*j -: 4] = x[63 - 4*i -: 4];
      else     y[63 - 4*i -: 4] = x[63 - 4*j -: 4];
    end
    return y;
  endfunction

  function automatic logic [63:0] rc(input logic [3:0] idx);
    case (idx)
      4'd1:    rc = 64'h13198a2e03707344;
      4'd2:    rc = 64'ha4093822299f31d0;
      4'd3:    rc = 64'h082efa98ec4e6c89;
      4'd4:    rc = 64'h452821e638d01377;
      4'd5:    rc = 64'hbe5466cf34e90c6c;
      4'd6:    rc = 64'h7ef84f78fd955cb1;
      4'd7:    rc = 64'h85840851f1ac43aa;
      4'd8:    rc = 64'hc882d32f25323c54;
      4'd9:    rc = 64'h64a51195e0e3610d;
      4'd10:   rc = 64'hd3b5a399ca0c2399;
      4'd11:   rc = 64'hc0ac29b7c97c50dd;
      default: rc = 64'h0000000000000000;
    endcase
  endfunction

  assign w_k0        = key[127:64];
  assign w_k1        = key[63:0];
  assign w_k0p       = {w_k0[0], w_k0[63:1]} ^ {63'b0, w_k0[63]};
  assign w_kw_in     = decrypt ? w_k0p : w_k0;
  assign w_kw_out_in = decrypt ? w_k0  : w_k0p;
  assign w_kc_in     = decrypt ? (w_k1 ^ ALPHA) : w_k1;

  // Forward and middle rounds share S and M' of the current state.
  assign w_rc     = rc(r_ctr);
  assign w_rk     = r_kc ^ w_rc;
  assign w_sx     = s_layer(r_state, 1'b0);
  assign w_msx    = m_prime(w_sx);
  assign w_fwd    = shift_rows(w_msx, 1'b0) ^ w_rk;
  assign w_mid    = s_layer(w_msx, 1'b1);
  assign w_iround = s_layer(m_prime(shift_rows(r_state ^ w_rk, 1'b1)), 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (start) w_fsm_nxt = FWD;
      FWD:     if (r_ctr == 4'd5) w_fsm_nxt = MID;
      MID:     w_fsm_nxt = INV;
      INV:     if (r_ctr == 4'd10) w_fsm_nxt = FIN;
      FIN:     w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_ctr_d   = r_ctr;
    w_load    = 1'b0;
    w_fin     = 1'b0;
    case (r_fsm)
      IDLE: if (start) begin
        w_state_d = din ^ w_kw_in ^ w_kc_in;  // RC0 is zero
        w_ctr_d   = 4'd1;
        w_load    = 1'b1;
      end
      FWD: begin
        w_state_d = w_fwd;
        w_ctr_d   = r_ctr + 4'd1;
      end
      MID: begin
        w_state_d = w_mid;
        w_ctr_d   = 4'd6;
      end
      INV: begin
        w_state_d = w_iround;
        w_ctr_d   = (r_ctr == 4'd10) ? 4'd0 : r_ctr + 4'd1;
      end
      FIN: begin
        w_fin   = 1'b1;
        w_ctr_d = 4'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= '0;
      r_ctr    <= '0;
      r_kw_out <= '0;
      r_kc     <= '0;
      r_dout   <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ctr   <= w_ctr_d;
      r_done  <= w_fin;
      r_busy  <= (w_fsm_nxt != IDLE);
      if (w_load) begin
        r_kw_out <= w_kw_out_in;
        r_kc     <= w_kc_in;
      end
      if (w_fin) r_dout <= r_state ^ r_kc ^ ALPHA ^ r_kw_out;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dout = r_dout;

endmodule

// File: tb/tb_prince_iter_core.sv
// Directed scoreboard bench for prince_iter_core: published PRINCE vectors, back-to-back
// decrypt, mid-operation input disturbance and asynchronous abort.
module tb_prince_iter_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         decrypt;
  logic [63:0]  din;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [63:0]  dout;

  logic [63:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  prince_iter_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .decrypt (decrypt),
    .din     (din),
    .key     (key),
    .busy    (busy),
    .done    (done),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the next posedge (E0), returns at the negedge after it.
  task automatic issue(input logic [63:0] d, input logic [127:0] k, input logic dec,
                       input logic [63:0] exp, input bit push);
    din = d; key = k; decrypt = dec; start = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges after E0; done must appear at the 13th.
  task automatic wait_done(input string tag, input bit disturb);
    int cyc;
    logic [63:0] want;
    cyc = 1;
    chk({tag, "_busy_hi"}, {63'b0, busy}, 64'd1);
    while (done !== 1'b1 && cyc < 40) begin
      if (disturb && cyc < 9) begin
        start   = 1'($urandom_range(1));
        key     = {$urandom, $urandom, $urandom, $urandom};
        din     = {$urandom, $urandom};
        decrypt = ~decrypt;
      end else if (disturb) begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, {63'b0, done}, 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'd13);
    chk({tag, "_busy_lo"}, {63'b0, busy}, 64'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      want = exp_q.pop_front();
      chk({tag, "_dout"}, dout, want);
    end
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; start = 1'b0; decrypt = 1'b0; din = '0; key = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_dout", dout, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(64'h0, 128'h0, 1'b0, 64'h818665aa0d02dfda, 1'b1);
    wait_done("enc_zero", 1'b0);
    @(negedge clk);
    chk("done_one_cycle", {63'b0, done}, 64'd0);
    repeat (3) @(negedge clk);
    chk("dout_hold_idle", dout, 64'h818665aa0d02dfda);

    issue(64'hffffffffffffffff, 128'h0, 1'b0, 64'h604ae6ca03c20ada, 1'b1);
    wait_done("enc_ones_din", 1'b0);

    issue(64'h0, {64'hffffffffffffffff, 64'h0}, 1'b0, 64'h9fb51935fc3df524, 1'b1);
    wait_done("enc_ones_k0", 1'b0);

    issue(64'h0, {64'h0, 64'hffffffffffffffff}, 1'b0, 64'h78a54cbe737bb7ef, 1'b1);
    wait_done("enc_ones_k1", 1'b0);

    issue(64'h0123456789abcdef, {64'h0, 64'hfedcba9876543210}, 1'b0, 64'hae25ad3ca8fa9ccf, 1'b1);
    wait_done("enc_mixed", 1'b0);
    // start raised in the done cycle
    issue(64'hae25ad3ca8fa9ccf, {64'h0, 64'hfedcba9876543210}, 1'b1, 64'h0123456789abcdef, 1'b1);
    wait_done("dec_b2b", 1'b0);

    issue(64'h818665aa0d02dfda, 128'h0, 1'b1, 64'h0, 1'b1);
    wait_done("dec_zero", 1'b0);

    issue(64'h0, {64'hffffffffffffffff, 64'h0}, 1'b0, 64'h9fb51935fc3df524, 1'b1);
    wait_done("disturb", 1'b1);

    issue(64'hffffffffffffffff, 128'h0, 1'b0, 64'h0, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_dout", dout, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    issue(64'hffffffffffffffff, 128'h0, 1'b0, 64'h604ae6ca03c20ada, 1'b1);
    wait_done("after_abort", 1'b0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
